// File: rtl/h80cpu_pkg.sv
// Shared h80cpu bus types and command encodings.
package h80cpu_pkg;

  typedef logic [15:0] bus_addr_t;
  typedef logic [7:0]  bus_data_t;
  typedef logic [2:0]  bus_cmd_t;

  localparam bus_cmd_t bus_cmd_nop     = 3'd0;
  localparam bus_cmd_t bus_cmd_read_b  = 3'd1;
  localparam bus_cmd_t bus_cmd_write_b = 3'd2;
  localparam bus_cmd_t bus_cmd_read_w  = 3'd3;
  localparam bus_cmd_t bus_cmd_write_w = 3'd4;

endpackage

// File: rtl/h80cpu_sync_bit.sv
// Multi-flop synchronizer for a single level/toggle signal from another clock domain.
module h80cpu_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain; all stages clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
    end
  end

  assign q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/h80cpu_io_arbiter.sv
// Round-robin arbiter sharing the h80cpu I/O target between several toggle-handshake masters.
module h80cpu_io_arbiter
  import h80cpu_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_run,
  input  bus_addr_t                  req_addr    [NUM_REQ],
  input  bus_cmd_t                   req_cmd     [NUM_REQ],
  input  bus_data_t                  req_wr_data [NUM_REQ],
  output logic [NUM_REQ-1:0]         req_done,
  output bus_data_t                  req_rd_data [NUM_REQ],
  output bus_addr_t                  io_addr,
  output bus_cmd_t                   io_cmd,
  output bus_data_t                  io_wr_data,
  output logic                       io_run,
  input  logic                       io_done,
  input  bus_data_t                  io_rd_data,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDW-1:0]   r_last;
  logic [IDW-1:0]   r_grant;
  logic [IDW-1:0]   w_winner;
  logic             w_any;
  logic [NUM_REQ-1:0] w_pend;
  logic             w_latch;
  logic             w_issue;
  logic             w_complete;
  logic             w_io_done_s;
  bus_addr_t        r_io_addr;
  bus_cmd_t         r_io_cmd;
  bus_data_t        r_io_wr_data;
  logic             r_io_run;

  h80cpu_sync_bit #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_done (
    .clk   (clk),
    .rst_n (reset),
    .d     (io_done),
    .q     (w_io_done_s)
  );

  assign w_pend = req_run ^ req_done;

  // Round-robin search: start one past the last served index, first pending index wins.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_any && w_pend[IDW'((int'(r_last) + k) % NUM_REQ)]) begin
        w_any    = 1'b1;
        w_winner = IDW'((int'(r_last) + k) % NUM_REQ);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and per-cycle datapath strobes.
  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_issue      = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_latch      = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_issue      = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_io_done_s == r_io_run) begin
          w_complete   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Latch the granted request one cycle before toggling io_run, and track the rotation pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_io_addr    <= '0;
      r_io_cmd     <= '0;
      r_io_wr_data <= '0;
      r_io_run     <= 1'b0;
      r_grant      <= '0;
      r_last       <= IDW'(NUM_REQ - 1);
    end else begin
      if (w_latch) begin
        r_io_addr    <= req_addr[w_winner];
        r_io_cmd     <= req_cmd[w_winner];
        r_io_wr_data <= req_wr_data[w_winner];
        r_grant      <= w_winner;
      end
      if (w_issue) begin
        r_io_run <= ~r_io_run;
      end
      if (w_complete) begin
        r_last <= r_grant;
      end
    end
  end

  // Per-requester completion toggle and read-data register; only the granted slot ever updates.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    logic      r_done_bit;
    bus_data_t r_rd_data;

    // Capture read data and flip the done toggle when this requester's transaction completes.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_done_bit <= 1'b0;
        r_rd_data  <= '0;
      end else if (w_complete && (r_grant == IDW'(gi))) begin
        r_done_bit <= ~r_done_bit;
        r_rd_data  <= io_rd_data;
      end
    end

    assign req_done[gi]    = r_done_bit;
    assign req_rd_data[gi] = r_rd_data;
  end

  assign io_addr    = r_io_addr;
  assign io_cmd     = r_io_cmd;
  assign io_wr_data = r_io_wr_data;
  assign io_run     = r_io_run;
  assign grant_id   = r_grant;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_h80cpu_io_arbiter.sv
// Directed bench for h80cpu_io_arbiter with a behavioural I/O-block model.
module tb_h80cpu_io_arbiter;
  import h80cpu_pkg::*;

  localparam int NR = 2;
  localparam int SS = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_run;
  bus_addr_t       req_addr    [NR];
  bus_cmd_t        req_cmd     [NR];
  bus_data_t       req_wr_data [NR];
  logic [NR-1:0]   req_done;
  bus_data_t       req_rd_data [NR];
  bus_addr_t       io_addr;
  bus_cmd_t        io_cmd;
  bus_data_t       io_wr_data;
  logic            io_run;
  logic            io_done;
  bus_data_t       io_rd_data;
  logic [0:0]      grant_id;
  logic            busy;

  int        n_checks = 0;
  int        n_pass   = 0;
  logic      tb_run;
  bus_data_t exp_rd0;

  h80cpu_io_arbiter #(
    .NUM_REQ     (NR),
    .SYNC_STAGES (SS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_run     (req_run),
    .req_addr    (req_addr),
    .req_cmd     (req_cmd),
    .req_wr_data (req_wr_data),
    .req_done    (req_done),
    .req_rd_data (req_rd_data),
    .io_addr     (io_addr),
    .io_cmd      (io_cmd),
    .io_wr_data  (io_wr_data),
    .io_run      (io_run),
    .io_done     (io_done),
    .io_rd_data  (io_rd_data),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Joint reset of arbiter, requesters and I/O model.
  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b0;
    req_run    = '0;
    io_done    = 1'b0;
    io_rd_data = '0;
    tb_run     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  // I/O-block model: wait for an io_run toggle, hold for delay cycles, then answer.
  task automatic io_serve(input bus_data_t rdat, input int delay, output int g, output bit ok,
                          output int extra, output int busy_low);
    ok = 1'b0; extra = 0; busy_low = 0; g = -1;
    for (int c = 0; c < 50 && !ok; c++) begin
      step();
      if (io_run !== tb_run) ok = 1'b1;
    end
    if (!ok) return;
    tb_run = io_run;
    g = int'(grant_id);
    $display("txn: grant=%0d addr=%h cmd=%0d wdata=%h rdata=%h delay=%0d",
             g, io_addr, io_cmd, io_wr_data, rdat, delay);
    for (int c = 0; c < delay; c++) begin
      step();
      if (io_run !== tb_run) extra++;
      if (busy !== 1'b1) busy_low++;
    end
    io_rd_data = rdat;
    io_done    = ~io_done;
  endtask

  // Wait (bounded) for req_done[idx] to flip; cycles counts edges from the call.
  task automatic wait_done(input int idx, output bit ok, output int cycles);
    logic prev;
    prev = req_done[idx];
    ok = 1'b0; cycles = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      step();
      if (req_done[idx] !== prev) begin
        ok = 1'b1;
        cycles = c + 1;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < NR; i++) begin
      req_addr[i] = '0; req_cmd[i] = '0; req_wr_data[i] = '0;
    end
    do_reset();
    n_checks++; if (req_done !== 2'b00) $display("FAIL rst_req_done: got %b want 00", req_done); else n_pass++;
    n_checks++; if (req_rd_data[0] !== 8'h00 || req_rd_data[1] !== 8'h00)
      $display("FAIL rst_rd_data: got %h/%h want 00/00", req_rd_data[0], req_rd_data[1]); else n_pass++;
    n_checks++; if (io_addr !== 16'h0 || io_cmd !== 3'd0 || io_wr_data !== 8'h0)
      $display("FAIL rst_io_fields: got %h/%0d/%h want 0/0/0", io_addr, io_cmd, io_wr_data); else n_pass++;
    n_checks++; if (io_run !== 1'b0 || grant_id !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_ctrl: got run=%b gid=%b busy=%b want 0/0/0", io_run, grant_id, busy); else n_pass++;
  endtask

  task automatic test_write_req0();
    bit ok; int cyc; int extra;
    req_addr[0] = 16'h0000; req_cmd[0] = bus_cmd_write_b; req_wr_data[0] = 8'h41;
    req_run[0] = ~req_run[0];
    step();
    n_checks++; if (busy !== 1'b1 || grant_id !== 1'b0)
      $display("FAIL wr_grant: got busy=%b gid=%b want 1/0", busy, grant_id); else n_pass++;
    n_checks++; if (io_addr !== 16'h0000 || io_cmd !== bus_cmd_write_b || io_wr_data !== 8'h41)
      $display("FAIL wr_fields: got %h/%0d/%h want 0000/2/41", io_addr, io_cmd, io_wr_data); else n_pass++;
    n_checks++; if (io_run !== 1'b0) $display("FAIL wr_run_early: got %b want 0", io_run); else n_pass++;
    step();
    n_checks++; if (io_run !== 1'b1) $display("FAIL wr_run_toggle: got %b want 1", io_run); else n_pass++;
    tb_run = io_run;
    $display("txn: grant=0 addr=%h cmd=%0d wdata=%h rdata=c3 delay=5", io_addr, io_cmd, io_wr_data);
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (io_run !== tb_run) extra++;
    end
    n_checks++; if (extra !== 0) $display("FAIL wr_run_once: got %0d extra toggles want 0", extra); else n_pass++;
    io_rd_data = 8'hC3;
    io_done = ~io_done;
    wait_done(0, ok, cyc);
    n_checks++; if (!ok || cyc !== SS + 1)
      $display("FAIL wr_done_latency: got ok=%b edges=%0d want ok=1 edges=%0d", ok, cyc, SS + 1); else n_pass++;
    n_checks++; if (req_rd_data[0] !== 8'hC3) $display("FAIL wr_rd_data: got %h want c3", req_rd_data[0]); else n_pass++;
    exp_rd0 = 8'hC3;
    n_checks++; if (busy !== 1'b0) $display("FAIL wr_idle: got busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_both_pending();
    bit ok; int g, extra, bl, cyc;
    do_reset();
    exp_rd0 = 8'h00;
    req_addr[0] = 16'h0100; req_cmd[0] = bus_cmd_read_b;  req_wr_data[0] = 8'h00;
    req_addr[1] = 16'h0200; req_cmd[1] = bus_cmd_write_b; req_wr_data[1] = 8'h7E;
    req_run = req_run ^ 2'b11;
    io_serve(8'h11, 4, g, ok, extra, bl);
    n_checks++; if (!ok || g !== 0 || extra !== 0)
      $display("FAIL both_first: got ok=%b gid=%0d extra=%0d want 1/0/0", ok, g, extra); else n_pass++;
    wait_done(0, ok, cyc);
    n_checks++; if (!ok || req_rd_data[0] !== 8'h11)
      $display("FAIL both_done0: got ok=%b rd=%h want 1/11", ok, req_rd_data[0]); else n_pass++;
    exp_rd0 = 8'h11;
    io_serve(8'h22, 4, g, ok, extra, bl);
    n_checks++; if (!ok || g !== 1 || extra !== 0 || io_wr_data !== 8'h7E)
      $display("FAIL both_second: got ok=%b gid=%0d extra=%0d wd=%h want 1/1/0/7e", ok, g, extra, io_wr_data); else n_pass++;
    wait_done(1, ok, cyc);
    n_checks++; if (!ok) $display("FAIL both_done1: got no toggle want toggle"); else n_pass++;
  endtask

  task automatic test_alternate();
    bit ok; int g, extra, bl, cyc;
    req_run = req_run ^ 2'b11;
    for (int k = 0; k < 4; k++) begin
      io_serve(8'h20 + 8'(k), 2, g, ok, extra, bl);
      n_checks++; if (!ok || g !== (k % 2))
        $display("FAIL alt_grant%0d: got ok=%b gid=%0d want 1/%0d", k, ok, g, k % 2); else n_pass++;
      if (ok && g >= 0) begin
        wait_done(g, ok, cyc);
        if (g == 0) exp_rd0 = 8'h20 + 8'(k);
        if (k < 2) req_run[g] = ~req_run[g];
      end
    end
  endtask

  task automatic test_long_stall();
    bit ok; int g, extra, bl, cyc;
    req_run = req_run ^ 2'b11;
    io_serve(8'h99, 1000, g, ok, extra, bl);
    n_checks++; if (!ok || g !== 0) $display("FAIL stall_grant: got ok=%b gid=%0d want 1/0", ok, g); else n_pass++;
    n_checks++; if (extra !== 0 || bl !== 0)
      $display("FAIL stall_hold: got extra=%0d busy_low=%0d want 0/0", extra, bl); else n_pass++;
    n_checks++; if ((req_run[1] ^ req_done[1]) !== 1'b1)
      $display("FAIL stall_pend1: got %b want 1", req_run[1] ^ req_done[1]); else n_pass++;
    wait_done(0, ok, cyc);
    exp_rd0 = 8'h99;
    n_checks++; if (!ok || req_rd_data[0] !== 8'h99)
      $display("FAIL stall_done: got ok=%b rd=%h want 1/99", ok, req_rd_data[0]); else n_pass++;
    io_serve(8'h33, 2, g, ok, extra, bl);
    n_checks++; if (!ok || g !== 1) $display("FAIL stall_next: got ok=%b gid=%0d want 1/1", ok, g); else n_pass++;
    wait_done(1, ok, cyc);
  endtask

  task automatic test_read_req1();
    bit ok; int g, extra, bl, cyc;
    req_addr[1] = 16'h0010; req_cmd[1] = bus_cmd_read_b; req_wr_data[1] = 8'h00;
    req_run[1] = ~req_run[1];
    io_serve(8'h5A, 3, g, ok, extra, bl);
    n_checks++; if (!ok || g !== 1 || io_addr !== 16'h0010 || io_cmd !== bus_cmd_read_b)
      $display("FAIL rd_fields: got ok=%b gid=%0d addr=%h cmd=%0d want 1/1/0010/1", ok, g, io_addr, io_cmd); else n_pass++;
    wait_done(1, ok, cyc);
    n_checks++; if (!ok || req_rd_data[1] !== 8'h5A)
      $display("FAIL rd_data1: got ok=%b rd=%h want 1/5a", ok, req_rd_data[1]); else n_pass++;
    n_checks++; if (req_rd_data[0] !== exp_rd0)
      $display("FAIL rd_data0_kept: got %h want %h", req_rd_data[0], exp_rd0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok; int g, extra, bl, cyc;
    req_addr[0] = 16'h0042; req_cmd[0] = bus_cmd_write_b; req_wr_data[0] = 8'hA5;
    req_run[0] = ~req_run[0];
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      step();
      if (io_run !== tb_run) ok = 1'b1;
    end
    step(); step();
    n_checks++; if (!ok || busy !== 1'b1) $display("FAIL mid_in_wait: got ok=%b busy=%b want 1/1", ok, busy); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++; if (req_done !== 2'b00 || req_rd_data[0] !== 8'h00 || req_rd_data[1] !== 8'h00)
      $display("FAIL mid_clr_req: got done=%b rd=%h/%h want 00/00/00", req_done, req_rd_data[0], req_rd_data[1]); else n_pass++;
    n_checks++; if (io_run !== 1'b0 || busy !== 1'b0 || grant_id !== 1'b0 || io_addr !== 16'h0 || io_wr_data !== 8'h0)
      $display("FAIL mid_clr_io: got run=%b busy=%b gid=%b addr=%h wd=%h want all 0", io_run, busy, grant_id, io_addr, io_wr_data); else n_pass++;
    req_run = '0; io_done = 1'b0; tb_run = 1'b0; io_rd_data = '0;
    repeat (3) step();
    n_checks++; if (req_done !== 2'b00) $display("FAIL mid_no_done: got %b want 00", req_done); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    step();
    req_run[0] = ~req_run[0];
    io_serve(8'h6B, 3, g, ok, extra, bl);
    n_checks++; if (!ok || g !== 0 || io_wr_data !== 8'hA5)
      $display("FAIL mid_fresh_grant: got ok=%b gid=%0d wd=%h want 1/0/a5", ok, g, io_wr_data); else n_pass++;
    wait_done(0, ok, cyc);
    n_checks++; if (!ok || req_done[0] !== 1'b1 || req_rd_data[0] !== 8'h6B)
      $display("FAIL mid_fresh_done: got ok=%b done=%b rd=%h want 1/1/6b", ok, req_done[0], req_rd_data[0]); else n_pass++;
  endtask

  initial begin
    reset = 1'b0;
    req_run = '0;
    io_done = 1'b0;
    io_rd_data = '0;
    tb_run = 1'b0;
    exp_rd0 = '0;
    test_reset();
    test_write_req0();
    test_both_pending();
    test_alternate();
    test_long_stall();
    test_read_req1();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
